// File: rtl/counter_arbiter_pkg.sv
// Shared types and constants for the two-requester counter arbiter.
package counter_arbiter_pkg;
  localparam int NREQ      = 2;
  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/arb_counter.sv
// Shared up-counter datapath with a limit register latched at grant time.
module arb_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  input  logic             load_lim,
  input  logic [WIDTH-1:0] lim_in,
  output logic [WIDTH-1:0] count,
  output logic             at_limit
);
  logic [WIDTH-1:0] lim_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      lim_q <= '0;
    end else begin
      if (load_lim) lim_q <= lim_in;
      if (clear)    count <= '0;
      else if (inc) count <= count + 1'b1;
    end
  end

  // Terminal detect stops the increment, so the counter never wraps.
  assign at_limit = (count == lim_q);
endmodule

// File: rtl/counter_arbiter.sv
// Round-robin arbiter sequencing counting runs of one shared counter for two requesters.
module counter_arbiter
  import counter_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [WIDTH-1:0]  limit0,
  input  logic [WIDTH-1:0]  limit1,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic [WIDTH-1:0]  count,
  output logic [NREQ-1:0]   done
);
  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             busy_q;
  logic             clear, inc, load_lim, at_limit, win;
  logic [WIDTH-1:0] lim_sel;

  arb_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .inc      (inc),
    .load_lim (load_lim),
    .lim_in   (lim_sel),
    .count    (count),
    .at_limit (at_limit)
  );

  // ptr_q holds the last granted requester; under contention the other one wins.
  assign win     = (req == 2'b11) ? ~ptr_q : req[1];
  assign lim_sel = win ? limit1 : limit0;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    clear    = 1'b0;
    inc      = 1'b0;
    load_lim = 1'b0;
    case (state_q)
      IDLE: begin
        clear = 1'b1;
        gnt_d = '0;
        if (|req) begin
          load_lim = 1'b1;
          ptr_d    = win;
          gnt_d    = win ? 2'b10 : 2'b01;
          state_d  = COUNT;
        end
      end
      COUNT: begin
        // A dropped request aborts the run even on the terminal count.
        if (!(|(req & gnt_q))) begin
          state_d = IDLE;
          clear   = 1'b1;
          gnt_d   = '0;
        end else if (at_limit) begin
          state_d = DONE;
          done_d  = gnt_q;
        end else begin
          inc = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        clear   = 1'b1;
        gnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        clear   = 1'b1;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b1;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= |gnt_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_counter_arbiter.sv
// Directed self-checking bench for counter_arbiter.
module tb_counter_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic [3:0] limit0 = 4'd0;
  logic [3:0] limit1 = 4'd0;
  logic [1:0] gnt;
  logic       busy;
  logic [3:0] count;
  logic [1:0] done;
  int checks = 0;
  int errors = 0;

  counter_arbiter #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .limit0(limit0), .limit1(limit1),
    .gnt(gnt), .busy(busy), .count(count), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, busy, count, done} !== 9'b0) begin
      errors++;
      $display("FAIL reset_init gnt=%b busy=%b count=%0d done=%b want all zero", gnt, busy, count, done);
    end
    tick();
    rst_n = 1'b1;
    tick();
    req = 2'b01; limit0 = 4'd7;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (count !== 4'd3) begin
      errors++;
      $display("FAIL reset_pre count=%0d want 3", count);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 2'b00 || count !== 4'd0 || done !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async gnt=%b busy=%b count=%0d done=%b want 00/0/0/00", gnt, busy, count, done);
    end
    tick();
    rst_n = 1'b1;
    req = 2'b11;
    tick();
    checks++;
    if (gnt !== 2'b01 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_win gnt=%b busy=%b want 01/1", gnt, busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 2'b01; limit0 = 4'd5;
    tick();
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (gnt !== 2'b01 || busy !== 1'b1 || count !== ((i > 5) ? 4'd5 : 4'(i)) ||
          done !== ((i == 6) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL single_c%0d gnt=%b busy=%b count=%0d done=%b want 01/1/%0d/%b",
                 i, gnt, busy, count, done, (i > 5) ? 5 : i, (i == 6) ? 2'b01 : 2'b00);
      end
      if (i == 6) req = 2'b00;
      tick();
    end
    checks++;
    if (gnt !== 2'b00 || busy !== 1'b0 || count !== 4'd0 || done !== 2'b00) begin
      errors++;
      $display("FAIL single_end gnt=%b busy=%b count=%0d done=%b want idle", gnt, busy, count, done);
    end
  endtask

  task automatic test_contention();
    int lim;
    logic [1:0] g;
    do_reset();
    req = 2'b11; limit0 = 4'd2; limit1 = 4'd3;
    tick();
    for (int r = 0; r < 4; r++) begin
      g   = (r % 2 == 0) ? 2'b01 : 2'b10;
      lim = (r % 2 == 0) ? 2 : 3;
      for (int i = 0; i < lim + 2; i++) begin
        checks++;
        if (gnt !== g || count !== ((i > lim) ? 4'(lim) : 4'(i)) ||
            done !== ((i == lim + 1) ? g : 2'b00)) begin
          errors++;
          $display("FAIL cont_r%0d_c%0d gnt=%b count=%0d done=%b want %b/%0d/%b",
                   r, i, gnt, count, done, g, (i > lim) ? lim : i, (i == lim + 1) ? g : 2'b00);
        end
        tick();
      end
      checks++;
      if (gnt !== 2'b00 || busy !== 1'b0) begin
        errors++;
        $display("FAIL cont_gap%0d gnt=%b busy=%b want 00/0", r, gnt, busy);
      end
      if (r == 3) req = 2'b00;
      tick();
    end
  endtask

  task automatic test_limits();
    do_reset();
    req = 2'b10; limit1 = 4'd0;
    tick();
    checks++;
    if (gnt !== 2'b10 || count !== 4'd0 || done !== 2'b00) begin
      errors++;
      $display("FAIL lim0_c0 gnt=%b count=%0d done=%b want 10/0/00", gnt, count, done);
    end
    tick();
    checks++;
    if (gnt !== 2'b10 || count !== 4'd0 || done !== 2'b10) begin
      errors++;
      $display("FAIL lim0_c1 gnt=%b count=%0d done=%b want 10/0/10", gnt, count, done);
    end
    req = 2'b00;
    tick();
    checks++;
    if (gnt !== 2'b00) begin
      errors++;
      $display("FAIL lim0_end gnt=%b want 00", gnt);
    end
    req = 2'b01; limit0 = 4'd15;
    tick();
    for (int i = 0; i < 17; i++) begin
      checks++;
      if (gnt !== 2'b01 || count !== ((i > 15) ? 4'd15 : 4'(i)) ||
          done !== ((i == 16) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL lim15_c%0d gnt=%b count=%0d done=%b want 01/%0d/%b",
                 i, gnt, count, done, (i > 15) ? 15 : i, (i == 16) ? 2'b01 : 2'b00);
      end
      if (i == 16) req = 2'b00;
      tick();
    end
    checks++;
    if (gnt !== 2'b00 || count !== 4'd0) begin
      errors++;
      $display("FAIL lim15_end gnt=%b count=%0d want 00/0", gnt, count);
    end
  endtask

  task automatic test_abort();
    do_reset();
    req = 2'b11; limit0 = 4'd7; limit1 = 4'd1;
    tick(); tick(); tick();
    checks++;
    if (gnt !== 2'b01 || count !== 4'd2) begin
      errors++;
      $display("FAIL abort_pre gnt=%b count=%0d want 01/2", gnt, count);
    end
    req = 2'b10;
    tick();
    checks++;
    if (gnt !== 2'b00 || count !== 4'd0 || done !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_cut gnt=%b busy=%b count=%0d done=%b want idle", gnt, busy, count, done);
    end
    tick();
    checks++;
    if (gnt !== 2'b10 || count !== 4'd0 || done !== 2'b00) begin
      errors++;
      $display("FAIL abort_next gnt=%b count=%0d done=%b want 10/0/00", gnt, count, done);
    end
  endtask

  task automatic test_limit_change();
    do_reset();
    req = 2'b01; limit0 = 4'd4;
    tick(); tick(); tick();
    checks++;
    if (count !== 4'd2) begin
      errors++;
      $display("FAIL lchg_pre count=%0d want 2", count);
    end
    limit0 = 4'd1;
    for (int i = 3; i < 6; i++) begin
      tick();
      checks++;
      if (gnt !== 2'b01 || count !== ((i > 4) ? 4'd4 : 4'(i)) ||
          done !== ((i == 5) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL lchg_c%0d gnt=%b count=%0d done=%b want 01/%0d/%b",
                 i, gnt, count, done, (i > 4) ? 4 : i, (i == 5) ? 2'b01 : 2'b00);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 2'b01; limit0 = 4'd1;
    tick(); tick(); tick();
    checks++;
    if (done !== 2'b01 || count !== 4'd1) begin
      errors++;
      $display("FAIL b2b_done done=%b count=%0d want 01/1", done, count);
    end
    tick();
    checks++;
    if (gnt !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap gnt=%b busy=%b want 00/0", gnt, busy);
    end
    tick();
    checks++;
    if (gnt !== 2'b01 || count !== 4'd0) begin
      errors++;
      $display("FAIL b2b_regrant gnt=%b count=%0d want 01/0", gnt, count);
    end
    req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_limits();
    test_abort();
    test_limit_change();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/counter_arbiter.md
# counter_arbiter

Single-clock arbiter/sequencer that shares one WIDTH-bit up-counter between two requesters. Each requester asks for a counting run to its own terminal value. The block grants the counter round-robin, sequences the run, and pulses a per-requester completion flag. It sits in front of the counter resource so that two clients never drive it at once.

## Interface
- WIDTH, 4, counter and limit width in bits
- clk  in  1  rising-edge clock for all state
- rst_n  in  1  asynchronous, active-low reset
- req  in  2  level request per requester; held high until done or voluntarily dropped
- limit0  in  WIDTH  terminal count for requester 0; sampled only at grant
- limit1  in  WIDTH  terminal count for requester 1; sampled only at grant
- gnt  out  2  one-hot grant; 00 when idle
- busy  out  1  high while any grant is active (gnt != 00)
- count  out  WIDTH  current value of the shared counter
- done  out  2  one-cycle pulse on the bit of the requester whose run completed

## Operation
- FSM states: IDLE, COUNT, DONE.
- **IDLE**
  - count = 0, gnt = 00.
  - If req != 00, choose a winner, latch its limit into lim_q, set gnt one-hot, go to COUNT.
- **Arbitration**
  - Round-robin on a 1-bit last-grant pointer.
  - If both requests are high, the requester not granted last wins.
  - If only one request is high, it wins.
  - The pointer updates on every grant.
- **COUNT**
  - count increments by 1 each cycle.
  - When count == lim_q, go to DONE on the next edge and hold count at lim_q.
  - If req[granted] drops, go to IDLE on the next edge: no done pulse, count cleared to 0, gnt cleared. The pointer still records this grant.
- **DONE**
  - done[granted] = 1 for exactly this cycle; gnt stays asserted; count holds lim_q.
  - Next state is always IDLE.
- **Arithmetic**
  - Unsigned WIDTH-bit counter. It never wraps, because terminal detection precedes overflow.
  - limit = 2^WIDTH−1 is legal and counts through the full range.
  - limit = 0 is legal: one COUNT cycle at count 0, then DONE.
- **Latched limit**: limit0 and limit1 are ignored outside the grant cycle. Changing them mid-run has no effect.
- **Reset values** (asserting rst_n low forces these immediately, from any state):
  - state = IDLE, gnt = 00, busy = 0, count = 0, done = 00, lim_q = 0
  - pointer = 1, so requester 0 wins the first contention.

## Timing
- req rises at edge N → gnt and busy are high after edge N+1, with count = 0 in that cycle.
- Run length: limit+1 COUNT cycles plus 1 DONE cycle, so gnt is high for limit+2 cycles.
- done pulse coincides with the last gnt cycle. gnt falls on the following edge.
- Minimum gap between grants is 1 IDLE cycle, so back-to-back runs are separated by one cycle with gnt = 00.
- If the requester keeps req high after done, it is re-arbitrated in that IDLE cycle. It wins only if the other request is low.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset deassertion is used synchronised upstream; the block itself adds no synchroniser.

## Structure
- **Shared package** counter_arbiter_pkg:
  - state enum (IDLE = 2'd0, COUNT = 2'd1, DONE = 2'd2)
  - requester count constant NREQ = 2
  - default WIDTH constant
- **Sub-module** arb_counter: the WIDTH-bit counter datapath.
  - Inputs: clear, inc, load_lim, lim_in.
  - Outputs: count, at_limit.
- The top level holds the FSM, the round-robin pointer and the output registers.

## Test plan
- **Reset**: rst_n low mid-COUNT (count = 3) → gnt = 00, count = 0, done = 00, busy = 0 in the same cycle; after release, req = 11 grants requester 0.
- **Single run**: req = 01, limit0 = 5 → gnt = 01 for 7 cycles, count sequence 0,1,2,3,4,5,5, done = 01 on the last cycle, then gnt = 00.
- **Contention**: req = 11 held, limit0 = 2, limit1 = 3 → grants alternate 01, 10, 01, …, each separated by one idle cycle; done pulses alternate 01, 10.
- **Limit edge cases**:
  - limit1 = 0 → gnt = 10 for 2 cycles, count stays 0, done = 10 on the second cycle.
  - limit0 = 15 → count reaches 15 with no wrap, done = 01.
- **Abort**: req0 dropped at count = 2 (limit0 = 7) → next cycle gnt = 00, count = 0, no done pulse; a pending req1 is granted in the following cycle.
- **Limit change mid-run**: limit0 changed from 4 to 1 at count = 2 → run still ends at count = 4 with done = 01.
